seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle CPU ALU. Adds configurable datapath width, a registered carry flag for ADC chains, and variable-distance shifts executed one bit per cycle.
- Valid/ready handshake on both input and output, so the control path can stall the ALU and the ALU can stall the control path.
- Sits between the register file read stage and the writeback/branch logic.

Parameters:
- WIDTH, 8, datapath width in bits (must be at least 2).
- SHW, $clog2(WIDTH), derived width of the shift-amount field. It is not overridden.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset (asserted when 0).
- in_valid  in  1  operation request.
- in_ready  out  1  ALU can accept a request; high only in IDLE.
- ALUOp  in  3  opcode.
- inA  in  WIDTH  operand A.
- inB  in  WIDTH  operand B; for shifts, inB[SHW-1:0] is the shift amount k.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- rslt  out  WIDTH  result.
- carry_out  out  1  carry, or last bit shifted out.
- taken  out  1  branch condition.
- carry_flag  out  1  current registered carry flag.

Behaviour:
- Reset (Reset=0 at an edge, any state, including mid-shift):
  - state goes to IDLE; any in-flight operation is discarded;
  - rslt=0, carry_out=0, taken=0, out_valid=0, carry_flag=0;
  - in_ready=1 from the first cycle after Reset returns to 1.
- Accept: in_valid && in_ready at an edge. ALUOp, inA, inB and k are captured. Input changes after acceptance are ignored.
- Opcodes:
  - 000 LD: rslt=inB.
  - 001 SRA: arithmetic right shift of inA by k. carry_out = last bit shifted out.
  - 010 ADD: {carry_out,rslt} = inA+inB. The sum is computed at WIDTH+1 bits.
  - 011 ADC: {carry_out,rslt} = inA+inB+carry_flag.
  - 100 XOR: rslt = inA^inB.
  - 101 SLL: logical left shift of inA by k. carry_out = last bit shifted out.
  - 110 TNEG: taken = inA[WIDTH-1]; rslt=0.
  - 111 TEQZ: taken = (inA==0); rslt=0.
- Defaults: carry_out=0 for non-arith/non-shift ops; taken=0 for non-test ops.
- carry_flag update: only on completion (entry to DONE) of ADD, ADC, SRA or SLL, and it takes the new carry_out. All other ops leave it unchanged.
- States: IDLE, SHIFT, DONE.
  - IDLE -> DONE on accepting a non-shift op. The result is computed combinationally and registered at the accept edge.
  - IDLE -> SHIFT on accepting SRA/SLL. The working register is loaded with inA, the counter with k, and the last-out bit is cleared.
  - SHIFT: if counter==0 -> DONE. Otherwise shift 1 bit, record the bit shifted out, and decrement the counter.
  - DONE: hold rslt/carry_out/taken and out_valid=1. On out_valid && out_ready -> IDLE.
- Latency, with t = accept cycle:
  - non-shift ops: out_valid in cycle t+1;
  - shift ops: out_valid in cycle t+2+k;
  - k=0: rslt=inA, carry_out=0, latency 2.
- Throughput:
  - At most one op in flight.
  - in_ready=0 in SHIFT and DONE; in_valid in those states is ignored.
  - There is no same-cycle DONE->accept bypass, so in_ready rises the cycle after the handshake.
- Stability: while out_valid=1 and out_ready=0, all outputs are held constant indefinitely.
- Width rules:
  - k ranges 0..WIDTH-1.
  - SRA replicates the MSB of inA. SLL fills with 0.
  - Add overflow wraps; the carry appears only in carry_out.

Decomposition:
- Shared package alu_pkg:
  - enum alu_op_t (LD, SRA, ADD, ADC, XOR, SLL, TNEG, TEQZ, with 3-bit encodings as above);
  - enum alu_state_t (IDLE, SHIFT, DONE).
- One sub-module, alu_shift_unit:
  - load/step interface: WIDTH working register, SHW counter, direction input, last-out bit, and a zero-count flag;
  - seq_alu holds the FSM, the combinational arith/logic, and the carry flag.

Test Plan:
- Reset mid-shift: SLL 0x01, k=5 accepted, Reset=0 two cycles later -> out_valid=0, rslt=0, carry_flag=0; in_ready=1 after release; a following ADC 0x00+0x00 gives 0x00, carry 0.
- Carry chain: ADD 0xF0+0x20 -> rslt=0x10, carry_out=1, out_valid at t+1; then ADC 0x01+0x01 -> rslt=0x03, carry_out=0, carry_flag=0.
- Shifts:
  - SRA 0x90, k=3 -> rslt=0xF2, carry_out=0, out_valid at t+5;
  - SLL 0x81, k=1 -> rslt=0x02, carry_out=1, carry_flag=1, out_valid at t+3;
  - SRA 0x55, k=0 -> rslt=0x55, carry_out=0, latency 2.
- Backpressure: XOR 0x0F^0xFF with out_ready=0 for 4 cycles -> rslt=0xF0 held, in_ready=0, an interleaved in_valid request is ignored; out_ready=1 -> IDLE, and the next op is accepted the following cycle.
- Tests: TEQZ inA=0x00 -> taken=1, rslt=0; TNEG inA=0x7F -> taken=0; TNEG inA=0x80 -> taken=1; carry_flag unchanged by all three.
- WIDTH=16: SLL 0x8001, k=15 -> rslt=0x8000, carry_out=0, latency 17; ADD 0xFFFF+0x0001 -> rslt=0x0000, carry_out=1.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode and state types for seq_alu
package alu_pkg;

  typedef enum logic [2:0] {
    OP_LD   = 3'b000,
    OP_SRA  = 3'b001,
    OP_ADD  = 3'b010,
    OP_ADC  = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLL  = 3'b101,
    OP_TNEG = 3'b110,
    OP_TEQZ = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift(alu_op_t op);
    return (op == OP_SRA) || (op == OP_SLL);
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// rtl/alu_shift_unit.sv - one-bit-per-cycle shifter with countdown and last-out bit
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             step,
  input  logic             left,
  input  logic [WIDTH-1:0] load_data,
  input  logic [SHW-1:0]   load_count,
  output logic [WIDTH-1:0] data,
  output logic             last_out,
  output logic             count_zero
);

  logic [SHW-1:0] count;
  logic           dir_left;

  assign count_zero = (count == '0);

  // Direction is latched at load so the top does not need to keep the opcode.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data     <= '0;
      count    <= '0;
      last_out <= 1'b0;
      dir_left <= 1'b0;
    end else if (load) begin
      data     <= load_data;
      count    <= load_count;
      last_out <= 1'b0;
      dir_left <= left;
    end else if (step && !count_zero) begin
      if (dir_left) begin
        last_out <= data[WIDTH-1];
        data     <= {data[WIDTH-2:0], 1'b0};
      end else begin
        last_out <= data[0];
        data     <= {data[WIDTH-1], data[WIDTH-1:1]};
      end
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU with valid/ready handshakes and registered carry
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUOp,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rslt,
  output logic             carry_out,
  output logic             taken,
  output logic             carry_flag
);

  alu_state_t       state, state_next;
  alu_op_t          op;
  logic             accept;
  logic             shift_load, shift_step;
  logic [WIDTH-1:0] sh_data;
  logic             sh_last, sh_zero;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] comb_rslt;
  logic             comb_carry, comb_taken;

  assign op        = alu_op_t'(ALUOp);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  alu_shift_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_shift (
    .clk        (Clk),
    .resetn     (Reset),
    .load       (shift_load),
    .step       (shift_step),
    .left       (op == OP_SLL),
    .load_data  (inA),
    .load_count (inB[SHW-1:0]),
    .data       (sh_data),
    .last_out   (sh_last),
    .count_zero (sh_zero)
  );

  // Carry-in only participates for ADC; the sum is one bit wider to expose the carry.
  assign sum = {1'b0, inA} + {1'b0, inB} + {{WIDTH{1'b0}}, (op == OP_ADC) && carry_flag};

  always_comb begin
    comb_rslt  = '0;
    comb_carry = 1'b0;
    comb_taken = 1'b0;
    case (op)
      OP_LD:   comb_rslt = inB;
      OP_ADD,
      OP_ADC:  {comb_carry, comb_rslt} = sum;
      OP_XOR:  comb_rslt = inA ^ inB;
      OP_TNEG: comb_taken = inA[WIDTH-1];
      OP_TEQZ: comb_taken = (inA == '0);
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    shift_load = 1'b0;
    shift_step = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          shift_load = is_shift(op);
          state_next = is_shift(op) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (sh_zero) state_next = DONE;
        else         shift_step = 1'b1;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      rslt       <= '0;
      carry_out  <= 1'b0;
      taken      <= 1'b0;
      carry_flag <= 1'b0;
    end else if (state == IDLE && accept && !is_shift(op)) begin
      rslt      <= comb_rslt;
      carry_out <= comb_carry;
      taken     <= comb_taken;
      if (op == OP_ADD || op == OP_ADC) carry_flag <= comb_carry;
    end else if (state == SHIFT && sh_zero) begin
      rslt       <= sh_data;
      carry_out  <= sh_last;
      taken      <= 1'b0;
      carry_flag <= sh_last;
    end
  end

endmodule
